// File: rtl/local_port_tx_flit_queue.sv
// Device-side TX flit FIFO feeding the local-port credit/VC coupling, with a registered launch stage.
// Optional feature: define LOCAL_TX_QUEUE_BYPASS_EN to let a flit skip storage when the queue is empty.
module local_port_tx_flit_queue #(
   parameter int unsigned FLIT_W      = 64,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned QUEUE_CNT_W = $clog2(QUEUE_DEPTH + 1),
   parameter int unsigned VC_ID_W     = 1,
   parameter int unsigned NODE_ID_X_W = 4,
   parameter int unsigned NODE_ID_Y_W = 4,
   parameter int unsigned QOS_W       = 4,
   parameter int unsigned IO_PORT_W   = 5
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   enq_vld_i,
   output logic                   enq_rdy_o,
   input  logic [FLIT_W-1:0]      enq_flit_i,
   input  logic [NODE_ID_X_W-1:0] enq_node_id_x_tgt_i,
   input  logic [NODE_ID_Y_W-1:0] enq_node_id_y_tgt_i,
   input  logic [QOS_W-1:0]       enq_qos_value_i,
   output logic                   head_vld_o,
   output logic [NODE_ID_X_W-1:0] head_node_id_x_tgt_o,
   output logic [NODE_ID_Y_W-1:0] head_node_id_y_tgt_o,
   output logic [QOS_W-1:0]       head_qos_value_o,
   input  logic                   free_credit_vld_i,
   input  logic [VC_ID_W-1:0]     free_credit_vc_id_i,
   input  logic [IO_PORT_W-1:0]   look_ahead_routing_i,
   output logic                   tx_flit_v_o,
   output logic [FLIT_W-1:0]      tx_flit_o,
   output logic [VC_ID_W-1:0]     tx_flit_vc_id_o,
   output logic [IO_PORT_W-1:0]   tx_flit_look_ahead_routing_o,
   output logic [QOS_W-1:0]       tx_flit_qos_value_o
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [QUEUE_CNT_W-1:0] FULL_CNT = QUEUE_CNT_W'(QUEUE_DEPTH);

   logic [FLIT_W-1:0]      flit_mem [QUEUE_DEPTH];
   logic [NODE_ID_X_W-1:0] x_mem    [QUEUE_DEPTH];
   logic [NODE_ID_Y_W-1:0] y_mem    [QUEUE_DEPTH];
   logic [QOS_W-1:0]       qos_mem  [QUEUE_DEPTH];

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [QUEUE_CNT_W-1:0] count_q, count_d;
   logic                   empty, bypass, byp_deq, deq, enq_fire, enq_store, deq_store;
   logic [FLIT_W-1:0]      head_flit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (count_q == '0);
   assign enq_rdy_o = (count_q != FULL_CNT);

`ifdef LOCAL_TX_QUEUE_BYPASS_EN
   assign bypass = empty & enq_vld_i;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      head_vld_o           = ~empty | bypass;
      head_flit            = flit_mem[rd_ptr_q];
      head_node_id_x_tgt_o = x_mem[rd_ptr_q];
      head_node_id_y_tgt_o = y_mem[rd_ptr_q];
      head_qos_value_o     = qos_mem[rd_ptr_q];
      if (bypass) begin
         head_flit            = enq_flit_i;
         head_node_id_x_tgt_o = enq_node_id_x_tgt_i;
         head_node_id_y_tgt_o = enq_node_id_y_tgt_i;
         head_qos_value_o     = enq_qos_value_i;
      end
   end

   // A bypassed flit that is consumed immediately never touches storage.
   assign deq       = head_vld_o & free_credit_vld_i;
   assign enq_fire  = enq_vld_i & enq_rdy_o;
   assign byp_deq   = bypass & free_credit_vld_i;
   assign enq_store = enq_fire & ~byp_deq;
   assign deq_store = deq & ~byp_deq;

   always_comb begin
      wr_ptr_d = enq_store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = deq_store ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      unique case ({enq_store, deq_store})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the cleared count marks every entry invalid.
   always_ff @(posedge clk) begin
      if (enq_store) begin
         flit_mem[wr_ptr_q] <= enq_flit_i;
         x_mem[wr_ptr_q]    <= enq_node_id_x_tgt_i;
         y_mem[wr_ptr_q]    <= enq_node_id_y_tgt_i;
         qos_mem[wr_ptr_q]  <= enq_qos_value_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_flit_v_o                  <= 1'b0;
         tx_flit_o                    <= '0;
         tx_flit_vc_id_o              <= '0;
         tx_flit_look_ahead_routing_o <= '0;
         tx_flit_qos_value_o          <= '0;
      end else begin
         tx_flit_v_o <= deq;
         if (deq) begin
            tx_flit_o                    <= head_flit;
            tx_flit_vc_id_o              <= free_credit_vc_id_i;
            tx_flit_look_ahead_routing_o <= look_ahead_routing_i;
            tx_flit_qos_value_o          <= head_qos_value_o;
         end
      end
   end

endmodule

// File: tb/tb_local_port_tx_flit_queue.sv
// Bench for local_port_tx_flit_queue: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_local_port_tx_flit_queue;
   localparam int unsigned FLIT_W = 64;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned XW = 4, YW = 4, QW = 4, LW = 5;
`ifdef LOCAL_TX_QUEUE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef struct packed {
      logic [FLIT_W-1:0] flit;
      logic [XW-1:0]     x;
      logic [YW-1:0]     y;
      logic [QW-1:0]     qos;
   } ent_t;

   logic clk, rstn;
   logic enq_vld, enq_rdy, credit, vc;
   logic [FLIT_W-1:0] enq_flit, tx_flit;
   logic [XW-1:0] enq_x, head_x;
   logic [YW-1:0] enq_y, head_y;
   logic [QW-1:0] enq_qos, head_qos, tx_qos;
   logic [LW-1:0] la, tx_la;
   logic head_vld, tx_v, tx_vc;

   ent_t mq[$];
   logic              exp_tx_v;
   logic [FLIT_W-1:0] exp_tx_flit;
   logic              exp_tx_vc;
   logic [LW-1:0]     exp_tx_la;
   logic [QW-1:0]     exp_tx_qos;
   logic [FLIT_W-1:0] saved [DEPTH];
   int vectors, miscompares;

   local_port_tx_flit_queue #(
      .FLIT_W(FLIT_W), .QUEUE_DEPTH(DEPTH), .VC_ID_W(1),
      .NODE_ID_X_W(XW), .NODE_ID_Y_W(YW), .QOS_W(QW), .IO_PORT_W(LW)
   ) dut (
      .clk(clk), .rstn(rstn),
      .enq_vld_i(enq_vld), .enq_rdy_o(enq_rdy), .enq_flit_i(enq_flit),
      .enq_node_id_x_tgt_i(enq_x), .enq_node_id_y_tgt_i(enq_y), .enq_qos_value_i(enq_qos),
      .head_vld_o(head_vld), .head_node_id_x_tgt_o(head_x), .head_node_id_y_tgt_o(head_y),
      .head_qos_value_o(head_qos),
      .free_credit_vld_i(credit), .free_credit_vc_id_i(vc), .look_ahead_routing_i(la),
      .tx_flit_v_o(tx_v), .tx_flit_o(tx_flit), .tx_flit_vc_id_o(tx_vc),
      .tx_flit_look_ahead_routing_o(tx_la), .tx_flit_qos_value_o(tx_qos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ent_t cur_ent();
      return '{flit: enq_flit, x: enq_x, y: enq_y, qos: enq_qos};
   endfunction
   function automatic bit m_rdy();
      return mq.size() != int'(DEPTH);
   endfunction
   function automatic bit m_byp();
      return BYPASS && mq.size() == 0 && enq_vld;
   endfunction
   function automatic bit m_hv();
      return mq.size() != 0 || m_byp();
   endfunction
   function automatic ent_t m_head();
      if (m_byp()) return cur_ent();
      if (mq.size() != 0) return mq[0];
      return '0;
   endfunction

   // Advance the reference model across one rising edge; returns at the next falling edge.
   task automatic tick();
      bit byp, deq, enq;
      ent_t h, in;
      byp = m_byp();
      h   = m_head();
      in  = cur_ent();
      deq = m_hv() && credit;
      enq = enq_vld && m_rdy();
      @(posedge clk);
      exp_tx_v = deq;
      if (deq) begin
         exp_tx_flit = h.flit;
         exp_tx_qos  = h.qos;
         exp_tx_vc   = vc;
         exp_tx_la   = la;
         if (!byp) void'(mq.pop_front());
      end
      if (enq && !(byp && deq)) mq.push_back(in);
      @(negedge clk);
   endtask

   task automatic clear_model();
      mq.delete();
      exp_tx_v = 0; exp_tx_flit = '0; exp_tx_vc = 0; exp_tx_la = '0; exp_tx_qos = '0;
   endtask

   task automatic idle_inputs();
      enq_vld = 0; credit = 0; vc = 0; la = '0;
      enq_flit = '0; enq_x = '0; enq_y = '0; enq_qos = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn = 0;
      clear_model();
      repeat (2) @(negedge clk);
      rstn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++; if (enq_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got %b want 1", enq_rdy); end
      vectors++; if (head_vld !== 1'b0) begin miscompares++; $display("FAIL reset_head_vld got %b want 0", head_vld); end
      vectors++; if (tx_v !== 1'b0) begin miscompares++; $display("FAIL reset_tx_v got %b want 0", tx_v); end
      vectors++; if (tx_flit !== '0) begin miscompares++; $display("FAIL reset_tx_flit got %h want 0", tx_flit); end
      vectors++; if ({tx_vc, tx_la, tx_qos} !== '0) begin miscompares++; $display("FAIL reset_tx_side got %h want 0", {tx_vc, tx_la, tx_qos}); end
   endtask

   task automatic test_single_flit();
      enq_vld = 1; enq_flit = 64'h11; enq_x = 1; enq_y = 2; enq_qos = 0;
      credit = 1; vc = 1; la = 5'h3;
      #1;
`ifdef LOCAL_TX_QUEUE_BYPASS_EN
      vectors++; if (head_vld !== 1'b1) begin miscompares++; $display("FAIL single_byp_head got %b want 1", head_vld); end
      vectors++; if (head_x !== 4'd1) begin miscompares++; $display("FAIL single_byp_x got %0d want 1", head_x); end
      tick();
      enq_vld = 0;
      #1;
`else
      vectors++; if (head_vld !== 1'b0) begin miscompares++; $display("FAIL single_head_t got %b want 0", head_vld); end
      tick();
      enq_vld = 0;
      #1;
      vectors++; if (head_vld !== 1'b1) begin miscompares++; $display("FAIL single_head_t1 got %b want 1", head_vld); end
      vectors++; if ({head_x, head_y} !== {4'd1, 4'd2}) begin miscompares++; $display("FAIL single_head_xy got %h want 12", {head_x, head_y}); end
      vectors++; if (tx_v !== 1'b0) begin miscompares++; $display("FAIL single_tx_t1 got %b want 0", tx_v); end
      tick();
      #1;
`endif
      vectors++; if (tx_v !== 1'b1) begin miscompares++; $display("FAIL single_tx_v got %b want 1", tx_v); end
      vectors++; if (tx_flit !== 64'h11) begin miscompares++; $display("FAIL single_tx_flit got %h want 11", tx_flit); end
      vectors++; if (tx_vc !== 1'b1) begin miscompares++; $display("FAIL single_tx_vc got %b want 1", tx_vc); end
      vectors++; if (tx_la !== 5'h3) begin miscompares++; $display("FAIL single_tx_la got %h want 3", tx_la); end
      credit = 0;
      tick();
      #1;
      vectors++; if (tx_v !== 1'b0) begin miscompares++; $display("FAIL single_tx_after got %b want 0", tx_v); end
      vectors++; if (head_vld !== 1'b0) begin miscompares++; $display("FAIL single_empty got %b want 0", head_vld); end
   endtask

   task automatic test_fill_full();
      credit = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         enq_vld = 1; enq_flit = {$urandom, $urandom}; enq_x = 4'($urandom); enq_y = 4'($urandom);
         enq_qos = 4'($urandom_range(0, 14));
         saved[i] = enq_flit;
         #1;
         vectors++; if (enq_rdy !== 1'b1) begin miscompares++; $display("FAIL fill_rdy[%0d] got %b want 1", i, enq_rdy); end
         tick();
      end
      enq_flit = {$urandom, $urandom};
      #1;
      vectors++; if (enq_rdy !== 1'b0) begin miscompares++; $display("FAIL full_rdy got %b want 0", enq_rdy); end
      tick();
      enq_vld = 0;
      #1;
      vectors++; if (enq_rdy !== 1'b0) begin miscompares++; $display("FAIL full_hold_rdy got %b want 0", enq_rdy); end
      vectors++; if (head_vld !== 1'b1) begin miscompares++; $display("FAIL full_head_vld got %b want 1", head_vld); end
   endtask

   task automatic test_full_deq();
      enq_vld = 1; enq_flit = {$urandom, $urandom}; credit = 1; vc = 0; la = 5'h11;
      #1;
      vectors++; if (enq_rdy !== 1'b0) begin miscompares++; $display("FAIL fulldeq_rdy got %b want 0", enq_rdy); end
      tick();
      enq_vld = 0; credit = 0;
      #1;
      vectors++; if (enq_rdy !== 1'b1) begin miscompares++; $display("FAIL fulldeq_rdy_next got %b want 1", enq_rdy); end
      vectors++; if (tx_v !== 1'b1 || tx_flit !== saved[0]) begin miscompares++; $display("FAIL fulldeq_tx got %b/%h want 1/%h", tx_v, tx_flit, saved[0]); end
      vectors++; if (mq.size() != 3 || mq[0].flit !== saved[1]) begin miscompares++; $display("FAIL fulldeq_model got size %0d want 3", mq.size()); end
      tick();
      #1;
      vectors++; if (enq_rdy !== 1'b1) begin miscompares++; $display("FAIL fulldeq_count3 got %b want 1", enq_rdy); end
      credit = 1;
      for (int i = 1; i < int'(DEPTH); i++) tick();
      credit = 0;
      #1;
      vectors++; if (head_vld !== 1'b0) begin miscompares++; $display("FAIL fulldeq_drained got %b want 0", head_vld); end
      vectors++; if (tx_flit !== saved[DEPTH-1]) begin miscompares++; $display("FAIL fulldeq_last got %h want %h", tx_flit, saved[DEPTH-1]); end
   endtask

   task automatic test_stream();
      logic [FLIT_W-1:0] got[$];
      int nxt;
      nxt = 0;
      tick();
      for (int cyc = 0; cyc < 80 && got.size() < 10; cyc++) begin
         enq_vld = (nxt < 10); enq_flit = FLIT_W'(nxt);
         enq_x = 4'($urandom); enq_y = 4'($urandom); enq_qos = 4'($urandom_range(0, 14));
         credit = (cyc % 2 == 0); vc = 1'($urandom); la = 5'($urandom);
         #1;
         vectors++; if (tx_v !== exp_tx_v) begin miscompares++; $display("FAIL stream_tx_v cyc %0d got %b want %b", cyc, tx_v, exp_tx_v); end
         if (tx_v === 1'b1) got.push_back(tx_flit);
         if (enq_vld && m_rdy()) nxt++;
         tick();
      end
      idle_inputs();
      #1;
      if (tx_v === 1'b1) got.push_back(tx_flit);
      vectors++; if (got.size() != 10) begin miscompares++; $display("FAIL stream_count got %0d want 10", got.size()); end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         vectors++; if (got[i] !== FLIT_W'(i)) begin miscompares++; $display("FAIL stream_order[%0d] got %0d want %0d", i, got[i], i); end
      end
      tick();
   endtask

   task automatic test_async_reset();
      credit = 0;
      for (int i = 0; i < 4; i++) begin
         enq_vld = 1; enq_flit = {$urandom, $urandom}; enq_qos = 4'($urandom);
         tick();
      end
      enq_vld = 0; credit = 1; vc = 1; la = 5'h1f;
      tick();
      credit = 0;
      #1;
      vectors++; if (tx_v !== 1'b1 || head_vld !== 1'b1) begin miscompares++; $display("FAIL areset_pre got %b%b want 11", tx_v, head_vld); end
      #2 rstn = 0;
      #1;
      vectors++; if (enq_rdy !== 1'b1 || head_vld !== 1'b0) begin miscompares++; $display("FAIL areset_q got %b%b want 10", enq_rdy, head_vld); end
      vectors++; if (tx_v !== 1'b0 || tx_flit !== '0) begin miscompares++; $display("FAIL areset_tx got %b/%h want 0/0", tx_v, tx_flit); end
      vectors++; if ({tx_vc, tx_la, tx_qos} !== '0) begin miscompares++; $display("FAIL areset_side got %h want 0", {tx_vc, tx_la, tx_qos}); end
      clear_model();
      @(negedge clk);
      rstn = 1;
      #1;
      vectors++; if (head_vld !== 1'b0 || enq_rdy !== 1'b1) begin miscompares++; $display("FAIL areset_release got %b%b want 01", head_vld, enq_rdy); end
   endtask

   task automatic test_rt_block();
      logic [FLIT_W-1:0] rt_flit, cm_flit;
      rt_flit = {$urandom, $urandom}; cm_flit = {$urandom, $urandom};
      credit = 0;
      enq_vld = 1; enq_flit = rt_flit; enq_qos = 4'hf;
      tick();
      enq_flit = cm_flit; enq_qos = 4'h0;
      tick();
      enq_vld = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++; if (tx_v !== 1'b0 || head_qos !== 4'hf) begin miscompares++; $display("FAIL rt_block[%0d] got %b/%h want 0/f", i, tx_v, head_qos); end
         tick();
      end
      credit = 1; vc = 1;
      tick();
      credit = 0;
      #1;
      vectors++; if (tx_v !== 1'b1 || tx_flit !== rt_flit || tx_qos !== 4'hf) begin miscompares++; $display("FAIL rt_first got %b/%h/%h want 1/%h/f", tx_v, tx_flit, tx_qos, rt_flit); end
      credit = 1; vc = 0;
      tick();
      credit = 0;
      #1;
      vectors++; if (tx_v !== 1'b1 || tx_flit !== cm_flit || tx_vc !== 1'b0) begin miscompares++; $display("FAIL rt_second got %b/%h want 1/%h", tx_v, tx_flit, cm_flit); end
      tick();
   endtask

   task automatic test_random();
      ent_t h;
      for (int cyc = 0; cyc < 300; cyc++) begin
         enq_vld = ($urandom_range(0, 3) != 0); credit = ($urandom_range(0, 2) != 0);
         enq_flit = {$urandom, $urandom}; enq_x = 4'($urandom); enq_y = 4'($urandom);
         enq_qos = ($urandom_range(0, 4) == 0) ? 4'hf : 4'($urandom);
         vc = 1'($urandom); la = 5'($urandom);
         #1;
         h = m_head();
         vectors++; if (enq_rdy !== m_rdy()) begin miscompares++; $display("FAIL rand_rdy cyc %0d got %b want %b", cyc, enq_rdy, m_rdy()); end
         vectors++; if (head_vld !== m_hv()) begin miscompares++; $display("FAIL rand_hv cyc %0d got %b want %b", cyc, head_vld, m_hv()); end
         if (m_hv()) begin
            vectors++; if ({head_x, head_y, head_qos} !== {h.x, h.y, h.qos}) begin miscompares++; $display("FAIL rand_head cyc %0d got %h want %h", cyc, {head_x, head_y, head_qos}, {h.x, h.y, h.qos}); end
         end
         vectors++; if (tx_v !== exp_tx_v) begin miscompares++; $display("FAIL rand_tx_v cyc %0d got %b want %b", cyc, tx_v, exp_tx_v); end
         if (exp_tx_v) begin
            vectors++; if ({tx_flit, tx_vc, tx_la, tx_qos} !== {exp_tx_flit, exp_tx_vc, exp_tx_la, exp_tx_qos}) begin
               miscompares++; $display("FAIL rand_tx_data cyc %0d got %h want %h", cyc, {tx_flit, tx_vc, tx_la, tx_qos}, {exp_tx_flit, exp_tx_vc, exp_tx_la, exp_tx_qos});
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rstn = 1; idle_inputs(); clear_model();
      @(negedge clk);
      test_reset();
      test_single_flit();
      test_fill_full();
      test_full_deq();
      test_stream();
      test_async_reset();
      test_rt_block();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/local_port_tx_flit_queue.md
# local_port_tx_flit_queue

Device-side transmit flit queue that sits directly upstream of the local port credit/VC coupling logic. It buffers flits issued by a local device and presents the head flit's target coordinates and QoS value to the coupling logic. When the coupling logic reports a free credit, the queue dequeues the head. It then launches the flit toward the router through a registered output stage, tagged with the granted VC id and the look-ahead routing result.

## Interface
Parameters:
- FLIT_W, 64: payload width in bits, excluding the routing/QoS side fields.
- QUEUE_DEPTH, 4: number of flit entries; must be ≥ 2; any value, not only powers of two.
- QUEUE_CNT_W, $clog2(QUEUE_DEPTH+1): occupancy counter width.
- VC_ID_W, 1: width of the VC id returned by the coupling logic.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- enq_vld_i  in  1  device offers a flit.
- enq_rdy_o  out  1  queue can accept; equals ~full from registered count; never depends combinationally on the dequeue.
- enq_flit_i  in  FLIT_W  payload.
- enq_node_id_x_tgt_i  in  NodeID_X_Width  target X.
- enq_node_id_y_tgt_i  in  NodeID_Y_Width  target Y.
- enq_qos_value_i  in  QoS_Value_Width  QoS value; all-ones selects the RT class.
- head_vld_o  out  1  head entry valid; drives the coupling logic's flit_vld_i.
- head_node_id_x_tgt_o  out  NodeID_X_Width  head target X.
- head_node_id_y_tgt_o  out  NodeID_Y_Width  head target Y.
- head_qos_value_o  out  QoS_Value_Width  head QoS.
- free_credit_vld_i  in  1  coupling logic has a credit for the head class.
- free_credit_vc_id_i  in  VC_ID_W  VC chosen by the coupling logic.
- look_ahead_routing_i  in  io_port_t  look-ahead routing for the head.
- tx_flit_v_o  out  1  flit launched to router this cycle.
- tx_flit_o  out  FLIT_W  launched payload.
- tx_flit_vc_id_o  out  VC_ID_W  VC id of the launched flit.
- tx_flit_look_ahead_routing_o  out  io_port_t  routing of the launched flit.
- tx_flit_qos_value_o  out  QoS_Value_Width  QoS of the launched flit.

## Operation
Enqueue and dequeue:
- Circular buffer of QUEUE_DEPTH entries, with a write pointer, a read pointer and an occupancy count.
- Pointers wrap from QUEUE_DEPTH-1 to 0.
- Enqueue fires when enq_vld_i & enq_rdy_o. The flit, X, Y and QoS are written at the write pointer, and the write pointer advances.
- Dequeue fires when head_vld_o & free_credit_vld_i, mirroring the coupling logic's consume condition exactly. The read pointer advances.

Occupancy count:
- Count is +1 on enqueue only, -1 on dequeue only, and unchanged when both fire.
- The count never exceeds QUEUE_DEPTH and never underflows.
- Full is count == QUEUE_DEPTH. When full, enq_rdy_o=0, even if a dequeue fires in the same cycle; the freed slot becomes visible the following cycle.

Head outputs:
- head_* are combinational reads at the read pointer.
- head_vld_o = (count != 0), except in the bypass case described under Configuration.

Output stage:
- On dequeue, the next cycle registers tx_flit_v_o=1, tx_flit_o, tx_flit_qos_value_o, tx_flit_vc_id_o ← free_credit_vc_id_i and tx_flit_look_ahead_routing_o ← look_ahead_routing_i.
- With no dequeue, the next cycle has tx_flit_v_o=0 and the data registers hold their previous values.
- There is no backpressure from the router; credits guarantee space.

Ordering and reset:
- Strict FIFO order, with no reordering across QoS classes. A blocked RT head blocks the queue.
- On reset assertion, at any time including mid-operation, pointers and count clear to 0 and all contents are discarded.
- Reset values: enq_rdy_o=1, head_vld_o=0, tx_flit_v_o=0, and all tx_* data outputs '0.
- No credit is tracked here; credit state lives in the coupling logic.

## Timing
- Output-stage latency: dequeue in cycle t gives tx_flit_v_o=1 in cycle t+1.
- Without the bypass, a flit enqueued into an empty queue in cycle t gives head_vld_o in cycle t+1. The earliest dequeue is t+1 and the earliest tx_flit_v_o is t+2.
- Sustained throughput is one flit per cycle while credits are available.
- Back-to-back dequeues produce tx_flit_v_o high on consecutive cycles, each with its own VC id.

## Configuration
- LOCAL_TX_QUEUE_BYPASS_EN defined:
  - When count == 0 and enq_vld_i=1, head_vld_o and head_* come directly from the enq_* inputs in the same cycle.
  - If free_credit_vld_i is also 1, the flit is dequeued without being written: pointers and count are unchanged, and tx_flit_v_o=1 at t+1.
  - If no credit is available, the flit is written normally.
- LOCAL_TX_QUEUE_BYPASS_EN undefined: no bypass; head_* always come from storage, and minimum enqueue-to-launch latency is 2 cycles.

## Test plan
- Reset, then enqueue flit A (payload 0x11, X=1, Y=2, QoS=0) with free_credit_vld_i=1 and vc_id=1. Without bypass: head_vld_o at t+1, and at t+2 tx_flit_v_o=1, tx_flit_o=0x11, tx_flit_vc_id_o=1. With bypass, tx_flit_v_o is high at t+1.
- Hold free_credit_vld_i=0 and enqueue 4 flits with DEPTH=4 → enq_rdy_o=0 after the 4th. A 5th enq_vld_i is not accepted and count stays 4.
- Full queue, then assert enq_vld_i and credit in the same cycle → dequeue fires, no enqueue, count=3, and enq_rdy_o=1 next cycle.
- Stream 10 flits (payload 0..9) through DEPTH=4 with credits toggling 1,0,1,0 → tx order is 0..9 with no loss or duplication, and pointers wrap correctly.
- Assert rstn low with 3 flits queued and tx_flit_v_o=1 → all outputs return to their reset values immediately (asynchronous), and head_vld_o=0 after release.
- RT head (QoS all-ones) with free_credit_vld_i=0 for 5 cycles, and a common flit behind it → no tx for those 5 cycles; on credit return the RT flit launches first.
